// File: rtl/mem_access_unit_if.sv
// Word-wide request/grant data memory port.
//   master : the access unit (drives mem_req/mem_we/mem_addr/mem_wdata)
//   slave  : the memory (drives mem_gnt/mem_rvalid/mem_rdata)
//   mem_req    - request pending
//   mem_we     - 1 = write, 0 = read
//   mem_addr   - word address
//   mem_wdata  - write word
//   mem_gnt    - request accepted this cycle
//   mem_rvalid - read data valid (earliest the cycle after the read grant)
//   mem_rdata  - read word
interface mem_access_unit_if #(
    parameter int ADDR_W = 10
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store executor.
// Turns the decoder's load/store control word into transactions on a
// request/grant word memory port. Byte loads select a lane and zero/sign
// extend; byte stores are done as read-modify-write. stall freezes the
// pipeline from the cycle the request appears until the completion cycle.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   req_valid           - MEM-stage instruction present (held while stall=1)
//   MemRead, MemWr      - load / store
//   IsByteW, IsByteB    - byte load / byte store
//   ExtopM              - 1 = sign-extend byte load
//   addr, wdata         - byte address, store data
//   rdata               - load result (updated only by completed loads)
//   done, err           - completion pulse, illegal-request pulse with done
//   stall               - pipeline freeze
//   mem                 - memory port (master side)
module mem_access_unit #(
    parameter int ADDR_W = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    input  logic                MemRead,
    input  logic                MemWr,
    input  logic                IsByteW,
    input  logic                IsByteB,
    input  logic                ExtopM,
    input  logic [31:0]         addr,
    input  logic [31:0]         wdata,
    output logic [31:0]         rdata,
    output logic                done,
    output logic                err,
    output logic                stall,
    mem_access_unit_if.master   mem
);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [1:0]        lane_q, lane_d;
    logic              is_load_q, is_load_d;
    logic              is_byte_q, is_byte_d;
    logic              ext_q, ext_d;
    logic              err_q, err_d;
    // Holds the store word; for byte stores it is replaced by the merged word
    // once the read returns, so WR_REQ always writes this register.
    logic [31:0]       wword_q, wword_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              access;
    logic              req_byte;
    logic              req_illegal;
    logic [7:0]        rd_byte;
    logic [31:0]       load_word;
    logic [31:0]       merged_word;
    logic              addr_hi_unused;

    assign addr_hi_unused = ^addr[31:ADDR_W+2];

    assign access      = req_valid & (MemRead | MemWr);
    assign req_byte    = MemRead ? IsByteW : IsByteB;
    assign req_illegal = (MemRead & MemWr) | (~req_byte & (addr[1:0] != 2'b00));

    assign rd_byte   = mem.mem_rdata[{lane_q, 3'b000} +: 8];
    assign load_word = is_byte_q ? {{24{ext_q & rd_byte[7]}}, rd_byte} : mem.mem_rdata;

    // Byte-store merge: only the addressed lane takes the store byte.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_merge
            assign merged_word[8*gi +: 8] = (lane_q == 2'(gi)) ? wword_q[7:0]
                                                               : mem.mem_rdata[8*gi +: 8];
        end
    endgenerate

    assign rdata         = rdata_q;
    assign mem.mem_addr  = waddr_q;
    assign mem.mem_wdata = wword_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            waddr_q   <= '0;
            lane_q    <= '0;
            is_load_q <= 1'b0;
            is_byte_q <= 1'b0;
            ext_q     <= 1'b0;
            err_q     <= 1'b0;
            wword_q   <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            waddr_q   <= waddr_d;
            lane_q    <= lane_d;
            is_load_q <= is_load_d;
            is_byte_q <= is_byte_d;
            ext_q     <= ext_d;
            err_q     <= err_d;
            wword_q   <= wword_d;
            rdata_q   <= rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        waddr_d     = waddr_q;
        lane_d      = lane_q;
        is_load_d   = is_load_q;
        is_byte_d   = is_byte_q;
        ext_d       = ext_q;
        err_d       = err_q;
        wword_d     = wword_q;
        rdata_d     = rdata_q;
        stall       = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        mem.mem_req = 1'b0;
        mem.mem_we  = 1'b0;

        case (state_q)
            IDLE: begin
                if (access) begin
                    stall     = 1'b1;
                    waddr_d   = addr[ADDR_W+1:2];
                    lane_d    = addr[1:0];
                    is_load_d = MemRead;
                    is_byte_d = req_byte;
                    ext_d     = ExtopM;
                    wword_d   = wdata;
                    err_d     = req_illegal;
                    if (req_illegal) begin
                        state_d = DONE;
                    end else if (MemRead || IsByteB) begin
                        state_d = RD_REQ;
                    end else begin
                        state_d = WR_REQ;
                    end
                end
            end
            RD_REQ: begin
                stall       = 1'b1;
                mem.mem_req = 1'b1;
                if (mem.mem_gnt) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                stall = 1'b1;
                if (mem.mem_rvalid) begin
                    if (is_load_q) begin
                        rdata_d = load_word;
                        state_d = DONE;
                    end else begin
                        wword_d = merged_word;
                        state_d = WR_REQ;
                    end
                end
            end
            WR_REQ: begin
                stall       = 1'b1;
                mem.mem_req = 1'b1;
                mem.mem_we  = 1'b1;
                if (mem.mem_gnt) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                err     = err_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid, MemRead, MemWr, IsByteW, IsByteB, ExtopM;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        done, err, stall;

    mem_access_unit_if #(.ADDR_W(10)) bus ();

    mem_access_unit #(.ADDR_W(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .MemRead   (MemRead),
        .MemWr     (MemWr),
        .IsByteW   (IsByteW),
        .IsByteB   (IsByteB),
        .ExtopM    (ExtopM),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .done      (done),
        .err       (err),
        .stall     (stall),
        .mem       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Memory seen by the DUT, and the reference memory kept by the model.
    logic [31:0] smem    [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic [31:0] exp_rdata;

    // Slave behaviour knobs and bookkeeping.
    int          gnt_delay = 0;
    int          rv_delay  = 0;
    logic        stray_rv  = 1'b0;
    int          n_rd = 0, n_wr = 0, stab_viol = 0;
    int          wcnt = 0, rd_cnt = 0;
    logic        waiting = 1'b0, rd_pend = 1'b0;
    logic [9:0]  rd_addr, last_ra, last_wa, p_addr;
    logic [31:0] last_wd, p_wdata;
    logic        p_we;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory slave: decisions taken on the falling edge so they are seen at
    // the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            bus.mem_gnt    = 1'b0;
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = 32'h0;
            rd_pend        = 1'b0;
            waiting        = 1'b0;
            wcnt           = 0;
        end else begin
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = $urandom;
            if (stray_rv) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = 32'hCAFEF00D;
            end
            if (rd_pend) begin
                if (rd_cnt == 0) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = smem[rd_addr];
                    rd_pend        = 1'b0;
                end else begin
                    rd_cnt--;
                end
            end
            bus.mem_gnt = 1'b0;
            if (bus.mem_req) begin
                if (waiting && (bus.mem_we !== p_we || bus.mem_addr !== p_addr ||
                                bus.mem_wdata !== p_wdata))
                    stab_viol++;
                if (wcnt >= gnt_delay) begin
                    bus.mem_gnt = 1'b1;
                    wcnt        = 0;
                    waiting     = 1'b0;
                    if (bus.mem_we) begin
                        smem[bus.mem_addr] = bus.mem_wdata;
                        last_wa = bus.mem_addr;
                        last_wd = bus.mem_wdata;
                        n_wr++;
                    end else begin
                        rd_pend = 1'b1;
                        rd_cnt  = rv_delay;
                        rd_addr = bus.mem_addr;
                        last_ra = bus.mem_addr;
                        n_rd++;
                    end
                end else begin
                    wcnt++;
                    waiting = 1'b1;
                    p_we    = bus.mem_we;
                    p_addr  = bus.mem_addr;
                    p_wdata = bus.mem_wdata;
                end
            end else begin
                wcnt    = 0;
                waiting = 1'b0;
            end
        end
    end

    function automatic logic [31:0] ref_load(input logic [31:0] w, input int lane,
                                             input logic isbyte, input logic ext);
        logic [31:0] b;
        if (!isbyte) return w;
        b = (w >> (8 * lane)) & 32'hFF;
        if (ext && b >= 32'd128) return b | 32'hFFFFFF00;
        return b;
    endfunction

    function automatic logic [31:0] ref_merge(input logic [31:0] w, input int lane,
                                              input logic [31:0] d);
        return (w & ~(32'hFF << (8 * lane))) | ((d & 32'hFF) << (8 * lane));
    endfunction

    // One instruction, entered and left at posedge+1.
    task automatic run(input logic rd, input logic wr, input logic bw, input logic bb,
                       input logic ext, input logic [31:0] a, input logic [31:0] wd,
                       input int g, input int rv, input string tag);
        logic isbyte, legal, got, got_err;
        logic [31:0] got_rdata;
        int exp_lat, cyc, stall_cnt, r0, w0, widx, lane;
        isbyte = rd ? bw : bb;
        legal  = !(rd && wr) && (isbyte || a[1:0] == 2'b00);
        widx   = int'(a[11:2]);
        lane   = int'(a[1:0]);
        if (!legal)   exp_lat = 1;
        else if (rd)  exp_lat = 3 + g + rv;
        else if (bb)  exp_lat = 4 + 2 * g + rv;
        else          exp_lat = 2 + g;
        if (legal) begin
            if (rd) exp_rdata = ref_load(ref_mem[widx], lane, bw, ext);
            else    ref_mem[widx] = bb ? ref_merge(ref_mem[widx], lane, wd) : wd;
        end
        gnt_delay = g;
        rv_delay  = rv;
        r0 = n_rd;
        w0 = n_wr;
        MemRead = rd; MemWr = wr; IsByteW = bw; IsByteB = bb; ExtopM = ext;
        addr = a; wdata = wd; req_valid = 1'b1;
        cyc = 0; stall_cnt = 0; got = 1'b0; got_err = 1'b0; got_rdata = 32'h0;
        while (!got && cyc < 60) begin
            #3;
            if (done) begin
                got       = 1'b1;
                got_err   = err;
                got_rdata = rdata;
                chk({tag, "_stall_at_done"}, 32'(stall), 32'd0);
                req_valid = 1'b0;
            end else begin
                if (stall) stall_cnt++;
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        req_valid = 1'b0;
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
        chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        chk({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(exp_lat));
        chk({tag, "_err"}, 32'(got_err), 32'(!legal));
        chk({tag, "_rdata"}, got_rdata, exp_rdata);
        chk({tag, "_reads"}, 32'(n_rd - r0), 32'(legal && (rd || bb)));
        chk({tag, "_writes"}, 32'(n_wr - w0), 32'(legal && wr));
        chk({tag, "_addr_data_stable"}, 32'(stab_viol), 32'd0);
        if (legal && wr) chk({tag, "_mem_word"}, smem[widx], ref_mem[widx]);
        $display("txn %-10s rd=%0b wr=%0b bw=%0b bb=%0b ext=%0b addr=%h wdata=%h g=%0d rv=%0d lat=%0d err=%0b rdata=%h",
                 tag, rd, wr, bw, bb, ext, a, wd, g, rv, cyc, got_err, got_rdata);
        @(posedge clk);
        #1;
        chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_done"},  32'(done), 32'd0);
        chk({tag, "_err"},   32'(err), 32'd0);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        chk({tag, "_req"},   32'(bus.mem_req), 32'd0);
        chk({tag, "_we"},    32'(bus.mem_we), 32'd0);
        chk({tag, "_maddr"}, 32'(bus.mem_addr), 32'd0);
        chk({tag, "_mwdata"}, bus.mem_wdata, 32'd0);
        chk({tag, "_rdata"}, rdata, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; MemRead = 1'b0; MemWr = 1'b0;
        IsByteW = 1'b0; IsByteB = 1'b0; ExtopM = 1'b0;
        addr = 32'h0; wdata = 32'h0;
        exp_rdata = 32'h0;
        for (int i = 0; i < 1024; i++) begin
            smem[i]    = $urandom;
            ref_mem[i] = smem[i];
        end
        smem[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
        smem[8] = 32'h80FF7F01; ref_mem[8] = 32'h80FF7F01;
        smem[1] = 32'h11223344; ref_mem[1] = 32'h11223344;

        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases.
        run(1, 0, 0, 0, 0, 32'h10, 32'h0, 0, 0, "lw");
        chk("lw_mem_addr", 32'(last_ra), 32'd4);
        chk("lw_const", rdata, 32'hDEADBEEF);
        run(1, 0, 1, 0, 1, 32'h23, 32'h0, 0, 0, "lb_23");
        chk("lb_23_const", rdata, 32'hFFFFFF80);
        run(1, 0, 1, 0, 0, 32'h23, 32'h0, 0, 0, "lbu_23");
        chk("lbu_23_const", rdata, 32'h00000080);
        run(1, 0, 1, 0, 1, 32'h21, 32'h0, 0, 0, "lb_21");
        chk("lb_21_const", rdata, 32'h0000007F);
        run(0, 1, 0, 1, 0, 32'h06, 32'h000000AA, 0, 0, "sb");
        chk("sb_wdata", last_wd, 32'h11AA3344);
        chk("sb_waddr", 32'(last_wa), 32'd1);
        run(0, 1, 0, 0, 0, 32'h40, 32'h12345678, 3, 0, "sw_bp");
        run(1, 0, 0, 0, 0, 32'h02, 32'h0, 0, 0, "lw_misal");
        run(1, 1, 0, 0, 0, 32'h20, 32'h0, 0, 0, "rd_and_wr");
        chk("illegal_rdata_kept", rdata, 32'h0000007F);

        // Flags with neither MemRead nor MemWr: not an access.
        req_valid = 1'b1; IsByteW = 1'b1; IsByteB = 1'b1; MemRead = 1'b0; MemWr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #3;
            chk("noacc_stall", 32'(stall), 32'd0);
            chk("noacc_done", 32'(done), 32'd0);
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        $display("txn noaccess  flags without MemRead/MemWr held 3 cycles");

        // Reset while waiting for read data, then a stray rvalid.
        gnt_delay = 0; rv_delay = 4;
        MemRead = 1'b1; MemWr = 1'b0; IsByteW = 1'b0; IsByteB = 1'b0;
        addr = 32'h10; req_valid = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #3;
        chk("rst_in_rdwait_req", 32'(bus.mem_req), 32'd0);
        chk("rst_in_rdwait_stall", 32'(stall), 32'd1);
        rst_n = 1'b0;
        req_valid = 1'b0;
        exp_rdata = 32'h0;
        #1;
        chk_all_zero("midrst");
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        stray_rv = 1'b1;
        @(posedge clk);
        #1;
        stray_rv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #3;
            chk_all_zero("stray_rv");
            @(posedge clk);
            #1;
        end
        $display("txn reset     reset in RD_WAIT followed by stray rvalid");

        // Randomized instructions against the reference model.
        for (int n = 0; n < 40; n++) begin
            int sel;
            logic rd, wr, bw, bb, ext;
            logic [31:0] a;
            sel = int'($urandom_range(0, 9));
            rd  = (sel <= 4);
            wr  = (sel == 0) || (sel >= 5);
            bw  = 1'($urandom_range(0, 1));
            bb  = 1'($urandom_range(0, 1));
            ext = 1'($urandom_range(0, 1));
            a   = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 9) < 7) a = a & 32'hFFFFFFFC;
            run(rd, wr, bw, bb, ext, a, $urandom,
                int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), "rand");
            repeat (int'($urandom_range(0, 2))) begin
                @(posedge clk);
                #1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage executor for the load/store control word produced by the pipeline decoder: MemRead, MemWr, IsByteW (byte load), IsByteB (byte store), ExtopM (byte-load sign extend).
- Turns each request into transactions on a word-wide, request/grant data memory port.
  - Byte loads: lane select plus zero/sign extension.
  - Byte stores: read-modify-write.
- Holds the pipeline with stall until the access completes.

Parameters:
ADDR_W, 10, word-address width of memory port; mem_addr = addr[ADDR_W+1:2]

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  MEM-stage instruction present (level, held while stall=1)
MemRead  input  1  load
MemWr  input  1  store
IsByteW  input  1  byte load (lb/lbu)
IsByteB  input  1  byte store (sb)
ExtopM  input  1  1 = sign-extend byte load, 0 = zero-extend
addr  input  32  byte address from ALU
wdata  input  32  store data (rt)
rdata  output  32  load result to writeback, valid with done
done  output  1  one-cycle completion pulse
err  output  1  one-cycle pulse with done on illegal request
stall  output  1  freeze IF..MEM while 1
mem_req  output  1  memory request
mem_we  output  1  1 = write
mem_addr  output  ADDR_W  word address
mem_wdata  output  32  write word
mem_gnt  input  1  request accepted this cycle
mem_rvalid  input  1  read data valid (earliest the cycle after grant)
mem_rdata  input  32  read word

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0, including rdata. Latched request fields cleared.
- Access = req_valid & (MemRead | MemWr). Capture of addr/wdata/flags happens only in IDLE, on the edge where access=1.
- stall = (state != IDLE && state != DONE) || (state == IDLE && access). It is combinational, so the pipeline freezes in the same cycle the request appears.
- States:
  - IDLE
    - Illegal request goes to DONE with err: MemRead & MemWr both 1, or word access with addr[1:0] != 0.
    - Load, or byte store, goes to RD_REQ.
    - Word store goes to WR_REQ.
  - RD_REQ: mem_req=1, mem_we=0, mem_addr=latched word address. On mem_gnt goes to RD_WAIT.
  - RD_WAIT: mem_req=0. On mem_rvalid:
    - Load: rdata updated, go to DONE.
    - Byte store: merged word captured, go to WR_REQ.
  - WR_REQ: mem_req=1, mem_we=1, mem_wdata = word (word store) or merged word (byte store). On mem_gnt goes to DONE.
  - DONE: done=1, stall=0, err as latched. Always goes to IDLE next cycle. req_valid is ignored in DONE; the next instruction is taken in IDLE.
- mem_addr and mem_wdata hold stable while mem_req=1 and mem_gnt=0.
- Byte lanes are little-endian: lane n = bits [8n+7:8n], n = addr[1:0].
  - Byte load: rdata = {24{ExtopM & b[7]}, b}.
  - Byte store merge: replace lane n with wdata[7:0]; keep the other three lanes of the read word.
- Word load: rdata = mem_rdata.
- rdata holds its value until the next completed load. Stores and errors leave it unchanged.
- Minimum latency, request cycle to done (gnt immediate, rvalid the cycle after gnt):
  - word load 3 cycles
  - word store 2 cycles
  - byte store 4 cycles
  - error 1 cycle
- mem_rvalid outside RD_WAIT is ignored. This includes a stale response after reset.
- Reset asserted mid-transaction aborts immediately, with no write issued. A WR_REQ already granted is complete on the memory side.
- Flag combinations with MemRead=0 and MemWr=0 are not an access: no stall, no done.

Test Plan:
- Word load: addr=0x10, mem_rdata=0xDEADBEEF, gnt immediate, rvalid 1 cycle later -> mem_addr=4, done 3 cycles after request, rdata=0xDEADBEEF, stall high exactly 3 cycles.
- lb/lbu: mem word 0x80FF7F01, addr=0x23, ExtopM=1 -> rdata=0xFFFFFF80. ExtopM=0 -> 0x00000080. addr=0x21, ExtopM=1 -> 0x0000007F.
- sb: mem word 0x11223344, addr=0x06, wdata=0x000000AA -> one read then one write, mem_wdata=0x11AA3344, mem_addr=1, done 4 cycles after request.
- Backpressure: word store with mem_gnt low 3 cycles -> mem_req, mem_we, mem_addr and mem_wdata stable throughout; done exactly 1 cycle after gnt.
- Illegal: lw with addr=0x02, then MemRead=MemWr=1 -> no mem_req, done+err next cycle, rdata unchanged.
- Reset in RD_WAIT, then a stray mem_rvalid after release -> all outputs 0, state IDLE, rdata stays 0, no done.
